bcd_scan_display: RTL
=====================

// Module: bcd_scan_display
// PURPOSE
//  Drives a 6-digit multiplexed 7-segment display from the frequency meter's latched 24-bit BCD result.
//  Sits directly downstream of the 24-bit result latch: bcd_in = latched q, load = latch strobe (lock).
//  Features:
//   - new values are double-buffered and applied only at a scan-frame boundary, so the display never tears
//   - leading zeros are blanked
//   - invalid BCD digits are flagged
// PARAMETERS
//  SCAN_DIV        1000  clk cycles each digit stays selected (>=2)
//  SEG_ACTIVE_LOW  0     1: invert seg and dig_sel (common-anode board)
// PORTS
//  clk      in   1   system clock, all logic on posedge
//  rst_n    in   1   asynchronous active-low reset
//  bcd_in   in   24  6 BCD digits; [3:0] = units (digit 0) ... [23:20] = digit 5
//  load     in   1   level strobe, synchronous to clk; capture on its rising edge
//  seg      out  7   {g,f,e,d,c,b,a}, active-high when SEG_ACTIVE_LOW=0
//  dig_sel  out  6   one-hot digit enable; bit k = digit k
//  err      out  1   high while the displayed value contains a digit >9
//  upd_ack  out  1   1-cycle pulse when the pending value is transferred to display
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - prescaler=0, digit index=0, pend_reg=0, pend_valid=0, disp_reg=0, load_d=0
//   - seg and dig_sel held at the "off" level (all 0, or all 1 if SEG_ACTIVE_LOW)
//   - err=0, upd_ack=0
//  Capture:
//   - rise = load & ~load_d
//   - on rise: pend_reg<=bcd_in, pend_valid<=1; a later rise before transfer overwrites pend_reg
//  Scan:
//   - prescaler counts 0..SCAN_DIV-1 and wraps; tick = (prescaler==SCAN_DIV-1)
//   - on tick: digit index increments 0->1->...->5->0
//   - frame boundary = tick while index==5
//  Transfer (at frame boundary only, if pend_valid):
//   - disp_reg<=pend_reg, pend_valid<=0, upd_ack=1 the next cycle
//   - rise in the same cycle as the boundary: disp_reg takes the OLD pend_reg, pend_reg takes bcd_in,
//     pend_valid stays 1
//   - rise on a boundary with pend_valid=0: no transfer; capture only
//  Blanking:
//   - digit k (k>=1) is blank iff disp_reg digits k..5 are all 4'h0
//   - digit 0 is never blank; a value of 0 shows a single "0"
//   - an invalid digit counts as nonzero
//  Decode:
//   - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F
//   - digit >9 shows E=79; blank shows 00 (hex, {g..a})
//  Output timing:
//   - seg, dig_sel and err are registered, with 1-cycle latency from the index/disp_reg change
//   - dig_sel is always exactly one-hot after the first post-reset cycle (never two digits at once)
//  err = any disp_reg digit >9; it updates with disp_reg
//  SEG_ACTIVE_LOW inverts seg and dig_sel only (not err or upd_ack)
// TESTING (SCAN_DIV=4, SEG_ACTIVE_LOW=0)
//  1. Release reset, no load -> dig_sel walks 01,02,04,08,10,20 (4 clk each) then wraps to 01;
//     seg=3F at digit 0, 00 elsewhere.
//  2. Pulse load with bcd_in=24'h000123 mid-frame -> unchanged until the boundary; then upd_ack pulses once;
//     digit0=4F, digit1=5B, digit2=06, digits3-5=00.
//  3. Two load pulses (24'h000111, then 24'h000222) in the same frame -> one upd_ack;
//     digits0-2 show 5B; 111 never displayed.
//  4. Load 24'h00A005 -> after the boundary digit0=6D, digit1=00? no: digits1-2=3F, digit3=79, digits4-5=00;
//     err=1. A later load of 24'h000005 -> err=0.
//  5. Load rise exactly on the frame-boundary cycle with a value pending -> old pending value displayed;
//     the new value is displayed at the next boundary.
//  6. Drive rst_n low mid-scan while 24'h999999 is displayed -> seg=00, dig_sel=00, err=0 immediately
//     (no clk edge); after release the display shows "0".

Source files
------------

// File: rtl/bcd_scan_display.sv
// Six-digit multiplexed 7-segment driver for a latched 24-bit BCD value.
// New values are double-buffered and swapped in only at a scan-frame boundary.
module bcd_scan_display #(
  parameter int SCAN_DIV       = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] bcd_in,
  input  logic        load,
  output logic [6:0]  seg,
  output logic [5:0]  dig_sel,
  output logic        err,
  output logic        upd_ack
);

  localparam int             PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [6:0]     SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [5:0]     DIG_OFF   = SEG_ACTIVE_LOW ? 6'h3F : 6'h00;

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [23:0]   pend_q, pend_d;
  logic          pend_valid_q, pend_valid_d;
  logic [23:0]   disp_q, disp_d;
  logic          load_q;
  logic [6:0]    seg_q, seg_d;
  logic [5:0]    dig_q, dig_d;
  logic          err_q, err_d;
  logic          upd_ack_q, upd_ack_d;

  logic       rise, tick, frame_end, xfer;
  logic [5:0] nz_from;
  logic [3:0] cur_digit;
  logic       blank;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h79;
    endcase
  endfunction

  assign rise      = load & ~load_q;
  assign tick      = (presc_q == PRESC_MAX);
  assign frame_end = tick && (idx_q == 3'd5);
  assign xfer      = frame_end && pend_valid_q;

  // Scan counters and double buffer. A capture coinciding with a transfer
  // keeps pend_valid set: the old pending value moves out, the new one waits.
  always_comb begin
    presc_d      = tick ? '0 : presc_q + 1'b1;
    idx_d        = idx_q;
    if (tick) idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    pend_d       = rise ? bcd_in : pend_q;
    pend_valid_d = rise ? 1'b1 : (xfer ? 1'b0 : pend_valid_q);
    disp_d       = xfer ? pend_q : disp_q;
    upd_ack_d    = xfer;
  end

  // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
  always_comb begin
    nz_from[5] = |disp_q[23:20];
    for (int k = 4; k >= 0; k--) nz_from[k] = nz_from[k+1] | (|disp_q[4*k +: 4]);
    err_d = 1'b0;
    for (int k = 0; k < 6; k++) if (disp_q[4*k +: 4] > 4'd9) err_d = 1'b1;
    cur_digit = disp_q[{idx_q, 2'b00} +: 4];
    blank     = (idx_q != 3'd0) && !nz_from[idx_q];
    seg_d     = (blank ? 7'h00 : decode(cur_digit)) ^ {7{SEG_ACTIVE_LOW}};
    dig_d     = (6'b000001 << idx_q) ^ {6{SEG_ACTIVE_LOW}};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= 3'd0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      disp_q       <= '0;
      load_q       <= 1'b0;
      seg_q        <= SEG_OFF;
      dig_q        <= DIG_OFF;
      err_q        <= 1'b0;
      upd_ack_q    <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      disp_q       <= disp_d;
      load_q       <= load;
      seg_q        <= seg_d;
      dig_q        <= dig_d;
      err_q        <= err_d;
      upd_ack_q    <= upd_ack_d;
    end
  end

  assign seg     = seg_q;
  assign dig_sel = dig_q;
  assign err     = err_q;
  assign upd_ack = upd_ack_q;

endmodule
